// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of data_mem, with
// a whole-memory fill sequencer used for initialization.
module data_mem_arbiter #(
    parameter int W = 8,
    parameter int A = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         init_start,
    input  logic [W-1:0] init_value,
    output logic         init_busy,
    output logic         init_done,
    input  logic         p0_req,
    input  logic         p0_we,
    input  logic [A-1:0] p0_addr,
    input  logic [W-1:0] p0_wdata,
    output logic         p0_gnt,
    output logic         p0_rvalid,
    output logic [W-1:0] p0_rdata,
    input  logic         p1_req,
    input  logic         p1_we,
    input  logic [A-1:0] p1_addr,
    input  logic [W-1:0] p1_wdata,
    output logic         p1_gnt,
    output logic         p1_rvalid,
    output logic [W-1:0] p1_rdata,
    output logic [A-1:0] mem_addr,
    output logic [W-1:0] mem_wdata,
    output logic         mem_re,
    output logic         mem_we,
    input  logic [W-1:0] mem_rdata
);

    typedef enum logic {
        IDLE,
        FILL
    } state_t;

    state_t       state_q;
    state_t       state_d;
    logic [A-1:0] cnt_q;
    logic [W-1:0] fill_q;
    // Port favoured on the next tie; flips away from each grantee.
    logic         rr_q;
    logic         done_q;
    logic         g0;
    logic         g1;
    logic         fill_last;

    assign fill_last = (cnt_q == {A{1'b1}});
    assign init_busy = (state_q == FILL);
    assign init_done = done_q;
    assign p0_gnt    = g0;
    assign p1_gnt    = g1;

    // Next state, grant selection and memory-side drive.
    always_comb begin
        state_d   = state_q;
        g0        = 1'b0;
        g1        = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (init_start) begin
                    state_d = FILL;
                end else begin
                    g0 = p0_req & (~p1_req | ~rr_q);
                    g1 = p1_req & (~p0_req | rr_q);
                    if (g0) begin
                        mem_addr  = p0_addr;
                        mem_wdata = p0_wdata;
                        mem_we    = p0_we;
                        mem_re    = ~p0_we;
                    end else if (g1) begin
                        mem_addr  = p1_addr;
                        mem_wdata = p1_wdata;
                        mem_we    = p1_we;
                        mem_re    = ~p1_we;
                    end
                end
            end
            FILL: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = fill_q;
                if (fill_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, fill counter/value, fairness pointer, done pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fill_q  <= '0;
            rr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FILL) && fill_last;
            if (state_q == IDLE && init_start) begin
                cnt_q  <= '0;
                fill_q <= init_value;
            end else if (state_q == FILL) begin
                cnt_q <= cnt_q + A'(1);
            end
            if (g0) begin
                rr_q <= 1'b1;
            end else if (g1) begin
                rr_q <= 1'b0;
            end
        end
    end

    // Capture read data for the port whose read was granted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
            p0_rdata  <= '0;
            p1_rdata  <= '0;
        end else begin
            p0_rvalid <= g0 & ~p0_we;
            p1_rvalid <= g1 & ~p1_we;
            if (g0 && !p0_we) begin
                p0_rdata <= mem_rdata;
            end
            if (g1 && !p1_we) begin
                p1_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural
// data_mem (combinational read, clocked write).
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_start;
    logic [7:0] init_value;
    logic       init_busy;
    logic       init_done;
    logic       p0_req, p0_we, p0_gnt, p0_rvalid;
    logic [7:0] p0_addr, p0_wdata, p0_rdata;
    logic       p1_req, p1_we, p1_gnt, p1_rvalid;
    logic [7:0] p1_addr, p1_wdata, p1_rdata;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       mem_re, mem_we;

    logic [7:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Memory model
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    data_mem_arbiter #(.W(8), .A(8)) dut (
        .clk(clk), .reset(reset),
        .init_start(init_start), .init_value(init_value),
        .init_busy(init_busy), .init_done(init_done),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    task automatic clear_inputs();
        init_start = 0; init_value = 0;
        p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 0;
        repeat (2) @(negedge clk);
        reset = 1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        @(negedge clk); #1;
        checks++;
        if ({p0_rvalid, p1_rvalid, init_busy, init_done, mem_we, mem_re} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000",
                {p0_rvalid, p1_rvalid, init_busy, init_done, mem_we, mem_re});
        end
        checks++;
        if ({p0_rdata, p1_rdata, mem_addr, mem_wdata} !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 00000000",
                {p0_rdata, p1_rdata, mem_addr, mem_wdata});
        end
        @(negedge clk);
        reset = 1;
    endtask

    task automatic test_write_read();
        @(negedge clk);
        p0_req = 1; p0_we = 1; p0_addr = 8'h10; p0_wdata = 8'h5A;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt, mem_we, mem_re} !== 4'b1010 || mem_addr !== 8'h10 || mem_wdata !== 8'h5A) begin
            errors++;
            $display("FAIL wr_grant got g%b%b we%b re%b a%h d%h want g10 we1 re0 a10 d5a",
                p0_gnt, p1_gnt, mem_we, mem_re, mem_addr, mem_wdata);
        end
        @(negedge clk);
        p0_we = 0; p0_wdata = 0;
        #1;
        checks++;
        if ({p0_gnt, mem_re, mem_we, p0_rvalid} !== 4'b1100 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL rd_grant got g%b re%b we%b rv%b a%h want g1 re1 we0 rv0 a10",
                p0_gnt, mem_re, mem_we, p0_rvalid, mem_addr);
        end
        @(negedge clk);
        p0_req = 0;
        #1;
        checks++;
        if (p0_rvalid !== 1'b1 || p0_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL rd_data got rv%b %h want rv1 5a", p0_rvalid, p0_rdata);
        end
        checks++;
        if (p1_rvalid !== 1'b0 || p1_rdata !== 8'h00 || p1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL p1_quiet got rv%b %h g%b want rv0 00 g0",
                p1_rvalid, p1_rdata, p1_gnt);
        end
        @(negedge clk); #1;
        checks++;
        if (p0_rvalid !== 1'b0 || p0_rdata !== 8'h5A) begin
            errors++;
            $display("FAIL rd_hold got rv%b %h want rv0 5a", p0_rvalid, p0_rdata);
        end
    endtask

    task automatic test_round_robin();
        logic e0;
        do_reset();
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 8'h20;
        p1_req = 1; p1_we = 0; p1_addr = 8'h30;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            #1;
            e0 = (i % 2 == 0);
            checks++;
            if (p0_gnt !== e0 || p1_gnt !== !e0 || mem_addr !== (e0 ? 8'h20 : 8'h30)) begin
                errors++;
                $display("FAIL rr_cycle%0d got g%b%b a%h want g%b%b a%h",
                    i, p0_gnt, p1_gnt, mem_addr, e0, !e0, e0 ? 8'h20 : 8'h30);
            end
        end
        @(negedge clk);
        p0_req = 0; p1_req = 0;
        #1;
        checks++;
        if (p1_rvalid !== 1'b1 || p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rr_rvalid got p0 %b p1 %b want 0 1", p0_rvalid, p1_rvalid);
        end
    endtask

    task automatic test_fill_wait();
        int bad = 0;
        @(negedge clk);
        init_start = 1; init_value = 8'hA5;
        p1_req = 1; p1_we = 0; p1_addr = 8'hFF;
        #1;
        checks++;
        if (p1_gnt !== 1'b0 || init_busy !== 1'b0) begin
            errors++;
            $display("FAIL fill_accept got g%b busy%b want g0 busy0", p1_gnt, init_busy);
        end
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 0) init_start = 0;
            if (i == 128) begin init_start = 1; init_value = 8'h22; end
            if (i == 129) init_start = 0;
            #1;
            checks++;
            if (init_busy !== 1 || mem_we !== 1 || mem_re !== 0 || mem_addr !== 8'(i) ||
                mem_wdata !== 8'hA5 || p0_gnt !== 0 || p1_gnt !== 0 || init_done !== 0) begin
                errors++;
                if (bad < 4)
                    $display("FAIL fill_cycle%0d got busy%b we%b re%b a%h d%h g%b%b dn%b want busy1 we1 re0 a%h da5 g00 dn0",
                        i, init_busy, mem_we, mem_re, mem_addr, mem_wdata,
                        p0_gnt, p1_gnt, init_done, 8'(i));
                bad++;
            end
        end
        @(negedge clk); #1;
        checks++;
        if (init_done !== 1 || init_busy !== 0 || p1_gnt !== 1 || mem_re !== 1 || mem_addr !== 8'hFF) begin
            errors++;
            $display("FAIL fill_end got dn%b busy%b g%b re%b a%h want dn1 busy0 g1 re1 aff",
                init_done, init_busy, p1_gnt, mem_re, mem_addr);
        end
        @(negedge clk);
        p1_req = 0;
        #1;
        checks++;
        if (p1_rvalid !== 1 || p1_rdata !== 8'hA5 || init_done !== 0) begin
            errors++;
            $display("FAIL fill_readback got rv%b %h dn%b want rv1 a5 dn0",
                p1_rvalid, p1_rdata, init_done);
        end
    endtask

    task automatic read_p0(input logic [7:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = a;
        @(negedge clk);
        p0_req = 0;
        #1;
        checks++;
        if (p0_rvalid !== 1 || p0_rdata !== exp) begin
            errors++;
            $display("FAIL %s got rv%b %h want rv1 %h", nm, p0_rvalid, p0_rdata, exp);
        end
    endtask

    task automatic test_reset_mid_fill();
        int seen = 0;
        @(negedge clk);
        init_start = 1; init_value = 8'h77;
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            if (i == 0) init_start = 0;
        end
        #1;
        checks++;
        if (mem_addr !== 8'd100 || init_busy !== 1) begin
            errors++;
            $display("FAIL abort_pos got a%h busy%b want a64 busy1", mem_addr, init_busy);
        end
        reset = 0;
        #1;
        checks++;
        if (init_busy !== 0 || mem_we !== 0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL abort_async got busy%b we%b a%h want busy0 we0 a00",
                init_busy, mem_we, mem_addr);
        end
        @(negedge clk);
        reset = 1;
        repeat (3) begin
            @(negedge clk); #1;
            if (init_done !== 0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d pulses want 0", seen);
        end
        read_p0(8'd50, 8'h77, "abort_addr50");
        read_p0(8'd200, 8'hA5, "abort_addr200");
    endtask

    task automatic test_rvalid_into_fill();
        @(negedge clk);
        p0_req = 1; p0_we = 0; p0_addr = 8'd50;
        #1;
        checks++;
        if (p0_gnt !== 1) begin
            errors++;
            $display("FAIL pre_fill_gnt got %b want 1", p0_gnt);
        end
        @(negedge clk);
        p0_addr = 8'd200; init_start = 1; init_value = 8'h11;
        #1;
        checks++;
        if (p0_gnt !== 0 || p0_rvalid !== 1 || p0_rdata !== 8'h77) begin
            errors++;
            $display("FAIL start_cycle got g%b rv%b %h want g0 rv1 77",
                p0_gnt, p0_rvalid, p0_rdata);
        end
        @(negedge clk);
        init_start = 0; p0_req = 0;
        #1;
        checks++;
        if (init_busy !== 1 || mem_addr !== 8'h00 || mem_wdata !== 8'h11 || p0_rdata !== 8'h77) begin
            errors++;
            $display("FAIL first_fill got busy%b a%h d%h rd%h want busy1 a00 d11 rd77",
                init_busy, mem_addr, mem_wdata, p0_rdata);
        end
        repeat (255) @(negedge clk);
        @(negedge clk);
        init_start = 1; init_value = 8'h33; p0_req = 1;
        #1;
        checks++;
        if (init_done !== 1 || p0_gnt !== 0) begin
            errors++;
            $display("FAIL restart_cycle got dn%b g%b want dn1 g0", init_done, p0_gnt);
        end
        @(negedge clk);
        init_start = 0;
        #1;
        checks++;
        if (init_busy !== 1 || mem_addr !== 8'h00 || mem_wdata !== 8'h33 || p0_gnt !== 0) begin
            errors++;
            $display("FAIL restart_fill got busy%b a%h d%h g%b want busy1 a00 d33 g0",
                init_busy, mem_addr, mem_wdata, p0_gnt);
        end
        @(negedge clk);
        p0_req = 0;
        reset = 0;
        @(negedge clk);
        reset = 1;
        read_p0(8'd200, 8'h11, "restart_addr200");
        read_p0(8'd0, 8'h33, "restart_addr0");
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_fill_wait();
        test_reset_mid_fill();
        test_rvalid_into_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
